// File: rtl/div_pkg.sv
// Shared encodings and constants for the iterative integer divider.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [5:0]  LAST_ITER = 6'd31;

  // Two's-complement negate when requested; used both for magnitudes and sign fix-up.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    logic signed [31:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract,
// keep the difference when it does not underflow and shift in the quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Trial subtraction; the partial remainder never exceeds XLEN bits after restore.
  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    fits    = (shifted >= {1'b0, divisor_i});
    diff    = shifted[XLEN-1:0] - divisor_i;
    if (fits) begin
      rem_o  = diff;
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = shifted[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-cycle DIV/DIVU/REM/REMU unit with a valid/ready result port.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_start,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic [4:0]      in_rd_address,
  input  logic            in_flush,
  input  logic            in_result_ready,
  output logic            out_busy,
  output logic            out_result_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_address
);
  import div_pkg::*;

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [4:0]      tag_q, tag_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] step_rem, step_quot;
  logic            is_signed, dvd_neg, dvs_neg, is_rem;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  // Next-state logic: capture in IDLE, iterate in RUN, sign fix-up and handshake in DONE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    result_d   = result_q;

    is_signed  = (in_op == OP_DIV) || (in_op == OP_REM);
    dvd_neg    = is_signed && in_dividend[XLEN-1];
    dvs_neg    = is_signed && in_divisor[XLEN-1];
    is_rem     = (op_q == OP_REM) || (op_q == OP_REMU);

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          op_d    = div_op_e'(in_op);
          tag_d   = in_rd_address;
          cnt_d   = 6'd0;
          valid_d = 1'b0;
          if (in_divisor == '0) begin
            // Divide by zero: architectural results, no iteration.
            quot_d     = ALL_ONES;
            rem_d      = in_dividend;
            dvs_d      = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = S_DONE;
          end else if (is_signed && in_dividend == INT_MIN && in_divisor == ALL_ONES) begin
            // Signed overflow: quotient wraps to INT_MIN, remainder is zero.
            quot_d     = INT_MIN;
            rem_d      = '0;
            dvs_d      = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            quot_d     = cond_neg(in_dividend, dvd_neg);
            rem_d      = '0;
            dvs_d      = cond_neg(in_divisor, dvs_neg);
            neg_quot_d = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!valid_q) begin
          if (tag_q == 5'd0) begin
            // Writes to x0 are dropped: no valid, straight back to IDLE.
            state_d = S_IDLE;
          end else begin
            valid_d  = 1'b1;
            result_d = is_rem ? cond_neg(rem_q, neg_rem_q) : cond_neg(quot_q, neg_quot_q);
          end
        end else if (in_result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (in_flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_DIV;
      cnt_q      <= 6'd0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      tag_q      <= 5'd0;
      valid_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
    end
  end

  assign out_busy         = (state_q != S_IDLE);
  assign out_result_valid = valid_q;
  assign out_result       = result_q;
  assign out_rd_address   = tag_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_start;
  logic [1:0]  in_op;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [4:0]  in_rd_address;
  logic        in_flush;
  logic        in_result_ready;
  logic        out_busy;
  logic        out_result_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd_address;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_start         (in_start),
    .in_op            (in_op),
    .in_dividend      (in_dividend),
    .in_divisor       (in_divisor),
    .in_rd_address    (in_rd_address),
    .in_flush         (in_flush),
    .in_result_ready  (in_result_ready),
    .out_busy         (out_busy),
    .out_result_valid (out_result_valid),
    .out_result       (out_result),
    .out_rd_address   (out_rd_address)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_op = op; in_dividend = a; in_divisor = b; in_rd_address = tag; in_start = 1'b1;
    step();
    in_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_start = 1'b0; in_op = 2'b00; in_dividend = '0; in_divisor = '0;
    in_rd_address = '0; in_flush = 1'b0; in_result_ready = 1'b1;
    repeat (2) step();
    checks++;
    if ({out_busy, out_result_valid, out_result, out_rd_address} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b vld=%b res=%h rd=%0d, want all zero",
               out_busy, out_result_valid, out_result, out_rd_address);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({out_busy, out_result_valid, out_result, out_rd_address} !== 39'd0) begin
      errors++;
      $display("FAIL reset_after: got busy=%b vld=%b res=%h rd=%0d, want all zero",
               out_busy, out_result_valid, out_result, out_rd_address);
    end
  endtask

  // Issue one request with ready high, check latency, value, tag and one-cycle valid.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int  k;
    bit  seen;
    in_result_ready = 1'b1;
    issue(op, a, b, tag);
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      step();
      k++;
      if (out_result_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || k != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got seen=%0b cycles=%0d, want %0d", name, seen, k, exp_lat);
    end
    checks++;
    if (out_result !== exp || out_rd_address !== tag) begin
      errors++;
      $display("FAIL %s_value: got res=%h rd=%0d, want res=%h rd=%0d",
               name, out_result, out_rd_address, exp, tag);
    end
    step();
    checks++;
    if (out_result_valid !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: got vld=%b busy=%b, want 0 0", name, out_result_valid, out_busy);
    end
  endtask

  task automatic test_divu_timing();
    in_result_ready = 1'b1;
    issue(DIVU, 32'd100, 32'd7, 5'd5);
    repeat (32) step();
    checks++;
    if (out_result_valid !== 1'b0 || out_busy !== 1'b1) begin
      errors++;
      $display("FAIL divu_e32: got vld=%b busy=%b, want 0 1", out_result_valid, out_busy);
    end
    step();
    checks++;
    if (out_result_valid !== 1'b1 || out_result !== 32'd14 || out_rd_address !== 5'd5) begin
      errors++;
      $display("FAIL divu_e33: got vld=%b res=%h rd=%0d, want 1 0000000e 5",
               out_result_valid, out_result, out_rd_address);
    end
    step();
    checks++;
    if (out_result_valid !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL divu_e34: got vld=%b busy=%b, want 0 0", out_result_valid, out_busy);
    end
  endtask

  task automatic test_ops();
    run_op("div_neg",   DIV,  32'hFFFF_FFF9, 32'd2,        5'd1, 32'hFFFF_FFFD, 33);
    run_op("rem_neg",   REM,  32'hFFFF_FFF9, 32'd2,        5'd2, 32'hFFFF_FFFF, 33);
    run_op("div_negdv", DIV,  32'd100,       32'hFFFF_FFF9, 5'd3, 32'hFFFF_FFF2, 33);
    run_op("rem_negdd", REM,  32'hFFFF_FF9C, 32'd7,        5'd4, 32'hFFFF_FFFE, 33);
    run_op("remu",      REMU, 32'd100,       32'd7,        5'd6, 32'd2,         33);
    run_op("divu_big",  DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd7, 32'd1,        33);
    run_op("divu_zero", DIVU, 32'h1234,      32'd0,        5'd8, 32'hFFFF_FFFF, 1);
    run_op("remu_zero", REMU, 32'h1234,      32'd0,        5'd9, 32'h1234,      1);
    run_op("div_ovf",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run_op("rem_ovf",   REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,        1);
  endtask

  task automatic test_stall();
    int k;
    in_result_ready = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 5'd9);
    k = 0;
    while (out_result_valid !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (k != 33) begin
      errors++;
      $display("FAIL stall_latency: got cycles=%0d, want 33", k);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_start = 1'b1; in_op = DIV; in_dividend = 32'd7; in_divisor = 32'd1; in_rd_address = 5'd1;
      end
      step();
      in_start = 1'b0;
      checks++;
      if (out_result_valid !== 1'b1 || out_result !== 32'd14 || out_rd_address !== 5'd9) begin
        errors++;
        $display("FAIL stall_hold%0d: got vld=%b res=%h rd=%0d, want 1 0000000e 9",
                 i, out_result_valid, out_result, out_rd_address);
      end
    end
    in_result_ready = 1'b1;
    in_start = 1'b1; in_op = DIVU; in_dividend = 32'd50; in_divisor = 32'd5; in_rd_address = 5'd3;
    step();
    checks++;
    if (out_result_valid !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got vld=%b busy=%b, want 0 0", out_result_valid, out_busy);
    end
    step();
    in_start = 1'b0;
    checks++;
    if (out_busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_next_accept: got busy=%b, want 1", out_busy);
    end
    k = 0;
    while (out_result_valid !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (k != 33 || out_result !== 32'd10 || out_rd_address !== 5'd3) begin
      errors++;
      $display("FAIL stall_next_value: got cycles=%0d res=%h rd=%0d, want 33 0000000a 3",
               k, out_result, out_rd_address);
    end
    step();
  endtask

  task automatic test_flush();
    int vcount;
    in_result_ready = 1'b1;
    issue(DIVU, 32'd1000, 32'd10, 5'd4);
    repeat (10) step();
    checks++;
    if (out_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got busy=%b, want 1", out_busy);
    end
    in_flush = 1'b1;
    step();
    checks++;
    if (out_busy !== 1'b0 || out_result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: got busy=%b vld=%b, want 0 0", out_busy, out_result_valid);
    end
    in_start = 1'b1;
    step();
    checks++;
    if (out_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_start: got busy=%b, want 0", out_busy);
    end
    in_flush = 1'b0; in_start = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_result_valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL flush_no_valid: got %0d valid cycles, want 0", vcount);
    end
    run_op("after_flush", DIVU, 32'd1000, 32'd10, 5'd4, 32'd100, 33);
  endtask

  task automatic test_reset_mid_run();
    int vcount;
    in_result_ready = 1'b1;
    issue(DIVU, 32'd1000, 32'd10, 5'd6);
    repeat (10) step();
    reset = 1'b0;
    step();
    checks++;
    if ({out_busy, out_result_valid, out_result, out_rd_address} !== 39'd0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b vld=%b res=%h rd=%0d, want all zero",
               out_busy, out_result_valid, out_result, out_rd_address);
    end
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_result_valid === 1'b1 || out_busy === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL midrun_quiet: got %0d active cycles, want 0", vcount);
    end
    run_op("after_reset", REMU, 32'd1000, 32'd7, 5'd6, 32'd6, 33);
  endtask

  task automatic test_tag_zero();
    int vcount;
    in_result_ready = 1'b1;
    issue(DIVU, 32'd100, 32'd7, 5'd0);
    vcount = 0;
    for (int i = 1; i <= 33; i++) begin
      step();
      if (out_result_valid === 1'b1) vcount++;
      if (i == 32) begin
        checks++;
        if (out_busy !== 1'b1) begin
          errors++;
          $display("FAIL tag0_done: got busy=%b at E0+32, want 1", out_busy);
        end
      end
    end
    checks++;
    if (out_busy !== 1'b0 || vcount != 0) begin
      errors++;
      $display("FAIL tag0_idle: got busy=%b valid_cycles=%0d, want 0 0", out_busy, vcount);
    end
  endtask

  initial begin
    test_reset();
    test_divu_timing();
    test_ops();
    test_stall();
    test_flush();
    test_reset_mid_run();
    test_tag_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits; only 32 is required to work.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_start  input  1  request to begin a division.
REQ-005 SHALL have port in_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port in_dividend  input  XLEN  rs1 value from the register file read port 1.
REQ-007 SHALL have port in_divisor  input  XLEN  rs2 value from the register file read port 2.
REQ-008 SHALL have port in_rd_address  input  5  destination register tag.
REQ-009 SHALL have port in_flush  input  1  abort any operation in flight.
REQ-010 SHALL have port in_result_ready  input  1  write-back consumer accepts the result.
REQ-011 SHALL have port out_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port out_result_valid  output  1  result and tag are valid.
REQ-013 SHALL have port out_result  output  XLEN  quotient or remainder, to the register file write data.
REQ-014 SHALL have port out_rd_address  output  5  captured tag, to the register file write address.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL accept a request only in IDLE with in_start=1; operands, in_op and in_rd_address are captured on that edge (E0).
REQ-017 SHALL ignore in_start in RUN and DONE; captured values stay unchanged.
REQ-018 SHALL, for a normal request, perform restoring division on magnitudes, one quotient bit per cycle, with 32 RUN cycles.
REQ-019 SHALL go to DONE on edge E0+32, with out_result_valid high from E0+33.
REQ-020 SHALL, for signed ops, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-021 SHALL, for divisor 0, set the quotient to 0xFFFFFFFF and the remainder to the dividend, skip RUN, and raise out_result_valid from E0+1.
REQ-022 SHALL, for DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF, set the quotient to 0x80000000 and the remainder to 0, skip RUN, and raise out_result_valid from E0+1.
REQ-023 SHALL hold out_result and out_rd_address stable in DONE while in_result_ready=0.
REQ-024 SHALL return to IDLE on the edge where out_result_valid=1 and in_result_ready=1.
REQ-025 SHALL not accept a new request in that same cycle; a new request is accepted no earlier than the next cycle.
REQ-026 SHALL return to IDLE on the next edge when in_flush=1 in any state, with no result produced.
REQ-027 SHALL give in_flush priority over in_start and over the result handshake.
REQ-028 SHALL drive out_result_valid=0 outside DONE.
REQ-029 SHALL never emit a result with out_rd_address=0 as valid; a request with tag 0 completes the handshake, but out_result_valid stays 0 and the FSM returns to IDLE one cycle after reaching DONE.

Reset
REQ-030 SHALL, on a rising edge with reset=0, enter IDLE and clear the counter, remainder, quotient, tag and sign flags, regardless of state.
REQ-031 SHALL hold out_busy=0, out_result_valid=0, out_result=0 and out_rd_address=0 during reset and the cycle after it.
REQ-032 SHALL, when reset occurs mid-RUN, discard the partial result.

Structure
REQ-033 SHALL place the op encodings, state encodings and the special-case constants (all-ones, 0x80000000) in a shared package div_pkg.
REQ-034 SHALL use one sub-module, div_step: a combinational single restoring iteration (shift, trial subtract, quotient bit), instantiated once.
REQ-035 SHALL use a 6-bit iteration counter; no multiplier or divider operators.

Verification
REQ-036 SHALL cover: DIVU 100/7, tag 5, ready=1 -> out_result=14, out_rd_address=5, valid exactly at E0+33 for one cycle.
REQ-037 SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-038 SHALL cover: DIVU 0x1234/0 -> 0xFFFFFFFF at E0+1; REMU 0x1234/0 -> 0x1234.
REQ-039 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both at E0+1.
REQ-040 SHALL cover: ready held low 5 cycles after valid, with in_start pulsed in DONE -> result stable, second request ignored, IDLE after the handshake.
REQ-041 SHALL cover: flush, then separately reset=0, 10 cycles into RUN -> out_busy=0 on the next edge, no valid ever seen, next request computes correctly.
